// File: rtl/button_press_classifier.sv
// Classifies button activity into short, long and double presses.
// Each class is a one-cycle registered pulse; every pulse bumps an 8-bit event counter.
module button_press_classifier #(
  parameter int unsigned c_LONG_CYCLES = 25000000,
  parameter int unsigned c_GAP_CYCLES  = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  output logic       o_Short,
  output logic       o_Long,
  output logic       o_Double,
  output logic [7:0] o_Event_Count
);

  localparam int unsigned CMAX = (c_LONG_CYCLES > c_GAP_CYCLES) ? c_LONG_CYCLES : c_GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(c_LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(c_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    GAP     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic [7:0]    count_q, count_d;

  // prev_q resets high so a button held through reset is not seen as a new press
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= i_Switch;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Switch && !prev_q) begin
          state_d = PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      // release is checked before the long limit, so it wins on the same cycle
      PRESS: begin
        if (!i_Switch) begin
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // a second press wins even when the gap counter is at its limit
      GAP: begin
        if (i_Switch) begin
          double_d = 1'b1;
          state_d  = RELEASE;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RELEASE: begin
        if (!i_Switch) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (short_d || long_d || double_d) begin
      count_d = count_q + 8'd1;
    end
  end

  assign o_Short       = short_q;
  assign o_Long        = long_q;
  assign o_Double      = double_q;
  assign o_Event_Count = count_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with short timing limits (long=8, gap=4).
module tb_button_press_classifier;

  logic       clk;
  logic       rst_n;
  logic       sw;
  logic       o_short;
  logic       o_long;
  logic       o_double;
  logic [7:0] o_count;

  int unsigned n_checks;
  int unsigned n_fail;

  button_press_classifier #(
    .c_LONG_CYCLES(8),
    .c_GAP_CYCLES (4)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw),
    .o_Short      (o_short),
    .o_Long       (o_long),
    .o_Double     (o_double),
    .o_Event_Count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the level sampled at the next posedge, then settle 1 time unit past it.
  task automatic step(input logic s);
    sw = s;
    @(posedge clk);
    #1;
  endtask

  // After this, the next posedge is "edge 1".
  task automatic do_reset();
    sw    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_short, o_long, o_double, o_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async_initial: got S/L/D/cnt=%b%b%b/%0d, required 000/0",
               o_short, o_long, o_double, o_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    n_checks++;
    if ({o_short, o_long, o_double, o_count} !== {3'b100, 8'd1}) begin
      n_fail++;
      $display("FAIL reset_pre_short: got S/L/D/cnt=%b%b%b/%0d, required 100/1",
               o_short, o_long, o_double, o_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_short, o_long, o_double, o_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async_clear: got S/L/D/cnt=%b%b%b/%0d, required 000/0",
               o_short, o_long, o_double, o_count);
    end
  endtask

  task automatic test_short();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      step((n >= 10) && (n <= 12));
      es = (n == 16); el = 1'b0; ed = 1'b0;
      ec = (n >= 16) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL short_press edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_long();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      step((n >= 10) && (n <= 30));
      es = 1'b0; el = (n == 17); ed = 1'b0;
      ec = (n >= 17) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL long_press edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_double();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      step(((n >= 10) && (n <= 11)) || ((n >= 14) && (n <= 20)));
      es = 1'b0; el = 1'b0; ed = (n == 14);
      ec = (n >= 14) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL double_press edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
    // Second press lands on the cycle the gap counter sits at its limit.
    do_reset();
    for (int n = 1; n <= 22; n++) begin
      step(((n >= 10) && (n <= 11)) || ((n >= 15) && (n <= 17)));
      es = 1'b0; el = 1'b0; ed = (n == 15);
      ec = (n >= 15) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL double_at_gap_limit edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_long_boundary();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 26; n++) begin
      step((n >= 10) && (n <= 16));
      es = (n == 20); el = 1'b0; ed = 1'b0;
      ec = (n >= 20) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL long_boundary edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 62; n++) begin
      if (n == 12) rst_n = 1'b0;
      if (n == 15) rst_n = 1'b1;
      step(((n >= 10) && (n <= 40)) || ((n >= 50) && (n <= 52)));
      es = (n == 56); el = 1'b0; ed = 1'b0;
      ec = (n >= 56) ? 8'd1 : 8'd0;
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL reset_mid_press edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic es, el, ed;
    logic [7:0] ec;
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      step((n == 3) || (n == 8) || (n == 11) || (n == 12));
      es = (n == 7); el = 1'b0; ed = (n == 11);
      ec = (n >= 11) ? 8'd2 : ((n >= 7) ? 8'd1 : 8'd0);
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {es, el, ed, ec}) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d: got S/L/D/cnt=%b%b%b/%0d, required %b%b%b/%0d",
                 n, o_short, o_long, o_double, o_count, es, el, ed, ec);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ec;
    do_reset();
    step(1'b0);
    for (int p = 1; p <= 257; p++) begin
      ec = 8'(p);
      step(1'b1);
      repeat (4) step(1'b0);
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {3'b100, ec}) begin
        n_fail++;
        $display("FAIL wrap_pulse press %0d: got S/L/D/cnt=%b%b%b/%0d, required 100/%0d",
                 p, o_short, o_long, o_double, o_count, ec);
      end
      step(1'b0);
      n_checks++;
      if ({o_short, o_long, o_double, o_count} !== {3'b000, ec}) begin
        n_fail++;
        $display("FAIL wrap_idle press %0d: got S/L/D/cnt=%b%b%b/%0d, required 000/%0d",
                 p, o_short, o_long, o_double, o_count, ec);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    sw       = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_long_boundary();
    test_reset_mid_press();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 The block SHALL have parameter c_LONG_CYCLES, default 25000000: consecutive pressed samples that classify a long press (1 s at 25 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter c_GAP_CYCLES, default 6250000: consecutive released samples after a short press that close the double-press window (250 ms at 25 MHz); legal range >= 2.
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is posedge i_Clk.
REQ-004 The block SHALL have port i_Rst_L, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_Switch, input, 1 bit: debounced, already i_Clk-synchronous button level; 1 = pressed.
REQ-006 The block SHALL have port o_Short, output, 1 bit: one-cycle pulse for a single short press.
REQ-007 The block SHALL have port o_Long, output, 1 bit: one-cycle pulse for a long press.
REQ-008 The block SHALL have port o_Double, output, 1 bit: one-cycle pulse for a double press.
REQ-009 The block SHALL have port o_Event_Count, output, 8 bits: running count of pulses emitted on o_Short, o_Long and o_Double.

Function
REQ-010 All outputs SHALL be registers; no combinational path from i_Switch to any output.
REQ-011 The FSM SHALL have four states: IDLE, PRESS, GAP, RELEASE.
REQ-012 Rising-edge detection SHALL use a registered previous level r_Prev; a press is i_Switch=1 with r_Prev=0.
REQ-013 In IDLE, a press SHALL move the FSM to PRESS and load the counter with 1; otherwise it stays in IDLE.
REQ-014 In PRESS with i_Switch=1: at counter == c_LONG_CYCLES-1, o_Long SHALL pulse and the FSM SHALL move to RELEASE; otherwise the counter increments.
REQ-015 In PRESS with i_Switch=0, the FSM SHALL move to GAP with counter = 1; release takes priority over the long limit on the same cycle.
REQ-016 In GAP with i_Switch=1, o_Double SHALL pulse and the FSM SHALL move to RELEASE; this includes the cycle where the counter is at its limit (press wins).
REQ-017 In GAP with i_Switch=0: at counter == c_GAP_CYCLES-1, o_Short SHALL pulse and the FSM SHALL move to IDLE; otherwise the counter increments.
REQ-018 In RELEASE, the FSM SHALL ignore the input until i_Switch=0, then move to IDLE; no pulse is emitted.
REQ-019 Latency: o_Long SHALL be high for the cycle after the c_LONG_CYCLES-th consecutive pressed sample.
REQ-020 Latency: o_Short SHALL be high for the cycle after the c_GAP_CYCLES-th consecutive released sample.
REQ-021 Latency: o_Double SHALL be high for the cycle after the first pressed sample in GAP.
REQ-022 At most one of o_Short, o_Long, o_Double SHALL be high in any cycle; each pulse is exactly one cycle.
REQ-023 o_Event_Count SHALL increment by 1, modulo 256, in the same edge that sets any pulse; it wraps from 255 to 0 silently.
REQ-024 Counter width SHALL be $clog2 of the larger of c_LONG_CYCLES and c_GAP_CYCLES, plus 1; the counter never exceeds that larger value.

Reset
REQ-025 While i_Rst_L=0, the block SHALL hold state IDLE, counter 0, r_Prev 1, all pulse outputs 0, and o_Event_Count 0, regardless of the clock.
REQ-026 Because r_Prev resets to 1, a button held through reset deassertion SHALL NOT register a press until it is released and pressed again.
REQ-027 Reset asserted mid-operation, in any state, SHALL abort the classification with no pulse emitted.

Verification (c_LONG_CYCLES=8, c_GAP_CYCLES=4; "edge n" = nth posedge after reset release)
REQ-028 Short press: i_Switch=1 at edges 10-12, 0 thereafter -> o_Short high only after edge 16; o_Event_Count=1; o_Long and o_Double stay 0.
REQ-029 Long press: i_Switch=1 at edges 10-30 -> o_Long high only after edge 17, with no other pulse; release at edge 31 -> IDLE, no o_Short; o_Event_Count=1.
REQ-030 Double press: i_Switch=1 at edges 10-11, 0 at 12-13, 1 at 14-20, 0 after -> o_Double high only after edge 14; no o_Short or o_Long; o_Event_Count=1.
REQ-031 Long/release boundary: i_Switch=1 at edges 10-16 (7 samples), 0 from edge 17 -> no o_Long; o_Short after edge 20.
REQ-032 Reset mid-press: i_Switch=1 at edges 10-40, i_Rst_L=0 from edge 12 to 14 -> all outputs 0 immediately; no pulse before release; a fresh press at edge 50 classifies normally.
REQ-033 Wrap: 256 short presses -> o_Event_Count returns to 0; the 257th gives 1.
